sin_sweep_ctrl: RTL

- Sequencer that drives the configuration side of the real-number sine source (`sin_src`) through a stepped frequency sweep.
- Each step: loads a frequency code and amplitude code into the source via a valid/ack handshake, then dwells for a programmed number of clock cycles.
- Sits between the test/control register layer and the sine source model.
- Gives benches and the top level a single start/abort/done interface for multi-tone stimulus runs.

---
 rtl/sin_src_pkg.sv | 26 ++
 rtl/sin_sweep_ctrl_if.sv | 27 ++
 rtl/sin_dwell_cnt.sv | 32 +++
 rtl/sin_sweep_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/sin_src_pkg.sv
// rtl/sin_src_pkg.sv - shared types, default widths and frequency arithmetic for the sine sweep
package sin_src_pkg;

    localparam int FREQ_W_DEF  = 16;
    localparam int AMP_W_DEF   = 12;
    localparam int DWELL_W_DEF = 16;
    localparam int NSTEP_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DWELL,
        FINISH
    } sweep_state_e;

    // Saturates at all-ones so a sweep past the top of the code range never wraps.
    function automatic logic [FREQ_W_DEF-1:0] sat_add_freq(
        input logic [FREQ_W_DEF-1:0] a,
        input logic [FREQ_W_DEF-1:0] b
    );
        logic [FREQ_W_DEF:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[FREQ_W_DEF] ? {FREQ_W_DEF{1'b1}} : sum[FREQ_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/sin_sweep_ctrl_if.sv
// rtl/sin_sweep_ctrl_if.sv - configuration update channel from the sweep controller to the sine source
interface sin_sweep_ctrl_if #(
    parameter int FREQ_W = sin_src_pkg::FREQ_W_DEF,
    parameter int AMP_W  = sin_src_pkg::AMP_W_DEF
);
    logic [FREQ_W-1:0] src_freq;
    logic [AMP_W-1:0]  src_amp;
    logic              src_en;
    logic              src_upd_valid;
    logic              src_upd_ack;

    modport master (
        output src_freq,
        output src_amp,
        output src_en,
        output src_upd_valid,
        input  src_upd_ack
    );

    modport slave (
        input  src_freq,
        input  src_amp,
        input  src_en,
        input  src_upd_valid,
        output src_upd_ack
    );
endinterface

// File: rtl/sin_dwell_cnt.sv
// rtl/sin_dwell_cnt.sv - loadable down-counter timing the per-tone dwell
module sin_dwell_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expired_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/sin_sweep_ctrl.sv
// rtl/sin_sweep_ctrl.sv - stepped frequency sweep sequencer for the sine source configuration port
module sin_sweep_ctrl
    import sin_src_pkg::*;
#(
    parameter int FREQ_W  = FREQ_W_DEF,
    parameter int AMP_W   = AMP_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int NSTEP_W = NSTEP_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [FREQ_W-1:0]  cfg_f_start,
    input  logic [FREQ_W-1:0]  cfg_f_step,
    input  logic [NSTEP_W-1:0] cfg_n_steps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [AMP_W-1:0]   cfg_amp,
    sin_sweep_ctrl_if.master   src,
    output logic [NSTEP_W-1:0] step_idx,
    output logic               busy,
    output logic               done
);
    sweep_state_e       state_q, state_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic [AMP_W-1:0]   amp_q, amp_d;
    logic [NSTEP_W-1:0] step_q, step_d;
    logic [FREQ_W-1:0]  f_step_q, f_step_d;
    logic [NSTEP_W-1:0] n_last_q, n_last_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               abort_q, abort_d;
    logic               cnt_load;
    logic               cnt_expired;

    sin_dwell_cnt #(.W(DWELL_W)) u_dwell_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (cnt_load),
        .value_i   (dwell_q - DWELL_W'(1)),
        .expired_o (cnt_expired)
    );

    always_comb begin
        state_d  = state_q;
        freq_d   = freq_q;
        amp_d    = amp_q;
        step_d   = step_q;
        f_step_d = f_step_q;
        n_last_d = n_last_q;
        dwell_d  = dwell_q;
        abort_d  = abort_q;
        cnt_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD;
                    freq_d   = cfg_f_start;
                    amp_d    = cfg_amp;
                    step_d   = '0;
                    f_step_d = cfg_f_step;
                    n_last_d = (cfg_n_steps == '0) ? '0 : cfg_n_steps - NSTEP_W'(1);
                    dwell_d  = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
                    abort_d  = 1'b0;
                end
            end
            LOAD: begin
                // valid may not drop mid-handshake, so an abort here waits for the transfer
                if (abort) begin
                    abort_d = 1'b1;
                end
                if (src.src_upd_ack) begin
                    abort_d = 1'b0;
                    if (abort || abort_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DWELL;
                        cnt_load = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_expired) begin
                    if (step_q == n_last_q) begin
                        state_d = FINISH;
                    end else begin
                        state_d = LOAD;
                        step_d  = step_q + NSTEP_W'(1);
                        freq_d  = sat_add_freq(freq_q, f_step_q);
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            freq_q   <= '0;
            amp_q    <= '0;
            step_q   <= '0;
            f_step_q <= '0;
            n_last_q <= '0;
            dwell_q  <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            amp_q    <= amp_d;
            step_q   <= step_d;
            f_step_q <= f_step_d;
            n_last_q <= n_last_d;
            dwell_q  <= dwell_d;
            abort_q  <= abort_d;
        end
    end

    assign src.src_freq      = freq_q;
    assign src.src_amp       = amp_q;
    assign src.src_en        = (state_q == LOAD) || (state_q == DWELL);
    assign src.src_upd_valid = (state_q == LOAD);
    assign step_idx          = step_q;
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == FINISH) && !abort;
endmodule
